pipelined_segment_adder: RTL and testbench



---
 rtl/pipelined_segment_adder.sv | 148 ++++++++++++++
 tb/tb_pipelined_segment_adder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_segment_adder.sv
// pipelined_segment_adder
// WIDTH-bit add/subtract split into WIDTH/SEG_WIDTH ripple segments, one
// segment per clock. The operands travel down the pipe next to the partial
// sum, so stage k adds segment k using the carry registered by stage k-1.
// A single advance enable moves every stage at once. This keeps ordering
// trivially correct under backpressure, at the cost of in_ready being a
// combinational function of out_ready.
module pipelined_segment_adder #(
    parameter int WIDTH     = 16,
    parameter int SEG_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG_WIDTH;
    localparam int LAST   = STAGES - 1;

    // Ripple add of one segment. Returns {carry_out, carry_into_top_bit, sum}.
    // The carry into the top bit is only consumed by the final stage, for ovf.
    function automatic logic [SEG_WIDTH+1:0] seg_add(
        input logic [SEG_WIDTH-1:0] x,
        input logic [SEG_WIDTH-1:0] y,
        input logic                 ci
    );
        logic [SEG_WIDTH-1:0] s;
        logic                 c;
        logic                 c_top;
        s     = {SEG_WIDTH{1'b0}};
        c     = ci;
        c_top = ci;
        for (int i = 0; i < SEG_WIDTH; i++) begin
            c_top = c;
            s[i]  = x[i] ^ y[i] ^ c;
            c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, c_top, s};
    endfunction

    logic                         en_s;
    logic [WIDTH-1:0]             b_eff_s;
    logic                         c0_s;

    logic [STAGES-1:0]            vld_r;
    logic [STAGES-1:0]            vld_nxt_s;
    logic [STAGES-1:0]            cout_r;
    logic [STAGES-1:0]            cout_nxt_s;
    logic [STAGES-1:0]            ovf_r;
    logic [STAGES-1:0]            ovf_nxt_s;
    logic [STAGES-1:0][WIDTH-1:0] sum_r;
    logic [STAGES-1:0][WIDTH-1:0] sum_nxt_s;
    logic [STAGES-1:0][WIDTH-1:0] a_r;
    logic [STAGES-1:0][WIDTH-1:0] a_nxt_s;
    logic [STAGES-1:0][WIDTH-1:0] b_r;
    logic [STAGES-1:0][WIDTH-1:0] b_nxt_s;
    logic                         unused_s;

    // Whole pipe advances unless a result is waiting and not being taken.
    always_comb begin
        en_s = !vld_r[LAST] || out_ready;
    end

    assign in_ready = en_s;

    // Subtraction is a + ~b + 1, so the incoming carry is forced high and Cin ignored.
    always_comb begin
        if (sub) begin
            b_eff_s = ~b;
            c0_s    = 1'b1;
        end else begin
            b_eff_s = b;
            c0_s    = Cin;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int               LO       = k * SEG_WIDTH;
        localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG_WIDTH{1'b1}}) << LO;

        logic                 src_vld_s;
        logic                 src_c_s;
        logic [WIDTH-1:0]     src_a_s;
        logic [WIDTH-1:0]     src_b_s;
        logic [WIDTH-1:0]     src_sum_s;
        logic [SEG_WIDTH+1:0] res_s;

        if (k == 0) begin : g_head
            assign src_vld_s = in_valid;
            assign src_a_s   = a;
            assign src_b_s   = b_eff_s;
            assign src_sum_s = {WIDTH{1'b0}};
            assign src_c_s   = c0_s;
        end else begin : g_body
            assign src_vld_s = vld_r[k-1];
            assign src_a_s   = a_r[k-1];
            assign src_b_s   = b_r[k-1];
            assign src_sum_s = sum_r[k-1];
            assign src_c_s   = cout_r[k-1];
        end

        assign res_s         = seg_add(src_a_s[LO +: SEG_WIDTH], src_b_s[LO +: SEG_WIDTH], src_c_s);
        assign vld_nxt_s[k]  = src_vld_s;
        assign a_nxt_s[k]    = src_a_s;
        assign b_nxt_s[k]    = src_b_s;
        assign sum_nxt_s[k]  = (src_sum_s & ~SEG_MASK) | (WIDTH'(res_s[SEG_WIDTH-1:0]) << LO);
        assign cout_nxt_s[k] = res_s[SEG_WIDTH+1];
        assign ovf_nxt_s[k]  = res_s[SEG_WIDTH+1] ^ res_s[SEG_WIDTH];
    end

    // Stage registers: shift together on en, hold otherwise; reset drops all in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r  <= {STAGES{1'b0}};
            cout_r <= {STAGES{1'b0}};
            ovf_r  <= {STAGES{1'b0}};
            sum_r  <= {(STAGES*WIDTH){1'b0}};
            a_r    <= {(STAGES*WIDTH){1'b0}};
            b_r    <= {(STAGES*WIDTH){1'b0}};
        end else if (en_s) begin
            vld_r  <= vld_nxt_s;
            cout_r <= cout_nxt_s;
            ovf_r  <= ovf_nxt_s;
            sum_r  <= sum_nxt_s;
            a_r    <= a_nxt_s;
            b_r    <= b_nxt_s;
        end
    end

    assign out_valid = vld_r[LAST];
    assign sum       = sum_r[LAST];
    assign carry     = cout_r[LAST];
    assign ovf       = ovf_r[LAST];

    // Operands are fully consumed by the last stage, and only its ovf is meaningful.
    assign unused_s = ^{a_r[LAST], b_r[LAST], ovf_r};

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Bench for pipelined_segment_adder at WIDTH=8, SEG_WIDTH=4 (two stages).
// A reference model computes each result with plain wide arithmetic and
// delays it through a STAGES-deep line that advances under the same global
// enable rule. A compare process checks the DUT against it on every negedge.
// Directed vectors carry literal expected values.
module tb_pipelined_segment_adder;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int WIDTH     = 8;
    localparam int SEG_WIDTH = 4;
    localparam int STAGES    = WIDTH / SEG_WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = 8'h00;
    logic [WIDTH-1:0] b = 8'h00;
    logic             Cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [9:0] got_q[$];

    always #5 clk = ~clk;

    pipelined_segment_adder #(.WIDTH(WIDTH), .SEG_WIDTH(SEG_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference result from whole-word arithmetic and sign rules.
    function automatic res_t ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic ci, input logic sb);
        logic [WIDTH:0]   t;
        logic [WIDTH-1:0] ye;
        res_t             r;
        ye  = sb ? ~y : y;
        t   = {1'b0, x} + {1'b0, ye} + {{WIDTH{1'b0}}, (sb ? 1'b1 : ci)};
        r.s = t[WIDTH-1:0];
        r.c = t[WIDTH];
        r.v = (x[WIDTH-1] == ye[WIDTH-1]) && (r.s[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    // Model: STAGES-deep delay line that advances when its head is empty or taken.
    logic [STAGES-1:0] m_vld;
    res_t              m_dat [STAGES];
    logic              m_en;
    assign m_en = !m_vld[STAGES-1] || out_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld <= '0;
            for (int i = 0; i < STAGES; i++) m_dat[i] <= '0;
        end else if (m_en) begin
            m_vld    <= {m_vld[STAGES-2:0], in_valid};
            m_dat[0] <= ref_add(a, b, Cin, sub);
            for (int i = 1; i < STAGES; i++) m_dat[i] <= m_dat[i-1];
        end
    end

    // Compare process: every cycle, against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_out_valid", out_valid, m_vld[STAGES-1]);
            check("m_in_ready", in_ready, m_en);
            if (m_vld[STAGES-1]) begin
                check("m_sum", sum, m_dat[STAGES-1].s);
                check("m_carry", carry, m_dat[STAGES-1].c);
                check("m_ovf", ovf, m_dat[STAGES-1].v);
            end
        end
    end

    // Output monitor: record each handshake, sampled just before the edge.
    always @(negedge clk) begin
        #3;
        if (rst_n && out_valid && out_ready) got_q.push_back({carry, ovf, sum});
    end

    // Offer one beat and hold it until accepted; returns 1ns after the accepting edge.
    task automatic drive_beat(input logic [7:0] xa, input logic [7:0] xb, input logic xc, input logic xs);
        logic ok;
        a = xa; b = xb; Cin = xc; sub = xs; in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk); #3;
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic directed(input string name, input logic [7:0] xa, input logic [7:0] xb,
                            input logic xc, input logic xs,
                            input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        drive_beat(xa, xb, xc, xs);
        lat = 99;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = t;
                break;
            end
        end
        check({name, "_lat"}, lat, STAGES);
        check({name, "_sum"}, sum, es);
        check({name, "_carry"}, carry, ec);
        check({name, "_ovf"}, ovf, eo);
        @(posedge clk); #1;
    endtask

    logic [7:0] sa [6] = '{8'h12, 8'hF0, 8'h7F, 8'h33, 8'h80, 8'hAB};
    logic [7:0] sb [6] = '{8'h34, 8'h20, 8'h7F, 8'h44, 8'h01, 8'hCD};
    logic [5:0] ssub = 6'b010110;
    logic [5:0] scin = 6'b100001;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] h_sum;
        logic             h_c;
        logic             h_o;
        logic [9:0]       obs;
        res_t             r;

        // Reset state.
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_carry", carry, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Directed vectors with hand-computed results.
        directed("add_basic", 8'h03, 8'h07, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b0);
        directed("add_chain", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        directed("add_segc",  8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        directed("sub_neg",   8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        directed("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        directed("sub_ovf",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Streaming with a 3-cycle stall once the first result appears.
        got_q.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) drive_beat(sa[i], sb[i], scin[i], ssub[i]);
            end
            begin
                for (int t = 0; t < 20; t++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                #1 out_ready = 1'b0;
                #1 check("bp_in_ready_drop", in_ready, 1'b0);
                h_sum = sum; h_c = carry; h_o = ovf;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_hold_valid", out_valid, 1'b1);
                    check("bp_hold_sum", sum, h_sum);
                    check("bp_hold_carry", carry, h_c);
                    check("bp_hold_ovf", ovf, h_o);
                end
                #1 out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("stream_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            r = ref_add(sa[i], sb[i], scin[i], ssub[i]);
            check("stream_result", got_q[i], {r.c, r.v, r.s});
        end

        // Bubbles: alternate in_valid, expect the same pattern two cycles later.
        obs = 10'd0;
        for (int i = 0; i < 10; i++) begin
            a = 8'(i * 3); b = 8'(i); Cin = 1'b0; sub = 1'b0;
            in_valid = (i < 8) ? ((i % 2) == 0) : 1'b0;
            @(negedge clk);
            obs[i] = out_valid;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bubble_pattern", obs, 10'h154);

        // Reset mid-stream with two beats in flight.
        drive_beat(8'h12, 8'h34, 1'b0, 1'b0);
        drive_beat(8'h56, 8'h11, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_sum", sum, 8'h00);
        check("mrst_carry", carry, 1'b0);
        check("mrst_ovf", ovf, 1'b0);
        @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mrst_no_ghost", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        directed("post_reset", 8'h21, 8'h13, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
